// File: rtl/display_timing.sv
// Raster timing generator: free-running h/v position counters with one aligned
// output register stage producing syncs, data-enable, coordinates and strobes.
module display_timing #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CW         = 10
) (
  input  logic          pixel_clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [CW-1:0] sx_q, sx_d;
  logic [CW-1:0] sy_q, sy_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          in_hsync, in_vsync;

  // NOTE: every signal gets a default at the top of always_comb, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end

    // Outputs are decoded from the pre-increment counts so they all describe
    // the same position one cycle later.
    in_hsync      = (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END);
    in_vsync      = (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END);
    sx_d          = h_cnt_q;
    sy_d          = v_cnt_q;
    de_d          = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    hsync_d       = in_hsync ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d       = in_vsync ? V_SYNC_POL : ~V_SYNC_POL;
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: default 640x480 instance plus a tiny-raster instance,
// checked every cycle against a linear-position model, with random resets.
module tb_display_timing;

  logic       clk   = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;

  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] sx_a, sy_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [3:0] sx_b, sy_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_a    = 0;   // edges since reset release, 0 while held in reset
  int n_b    = 0;

  // Run-length and interval trackers
  int hs_run_a = 0, de_run_a = 0, ls_last_a = -1;
  int vs_run_b = 0, hs_run_b = 0, de_run_b = 0, fs_last_b = -1;

  typedef struct packed {
    logic        hs, vs, de, ls, fs;
    logic [15:0] sx, sy;
  } obs_t;

  display_timing dut_a (
    .pixel_clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .sx(sx_a), .sy(sy_a), .line_start(ls_a), .frame_start(fs_a)
  );

  display_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(4)
  ) dut_b (
    .pixel_clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .sx(sx_b), .sy(sy_b), .line_start(ls_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  // Expected outputs after n edges since release: position n-1 in raster order.
  function automatic obs_t model(int n, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb,
                                 logic hp, logic vp);
    obs_t e;
    int ht, vt, p, x, y;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (n == 0) begin
      e = '0;
      e.hs = ~hp;
      e.vs = ~vp;
      return e;
    end
    p    = (n - 1) % (ht * vt);
    x    = p % ht;
    y    = p / ht;
    e.sx = 16'(x);
    e.sy = 16'(y);
    e.de = (x < ha) && (y < va);
    e.hs = (x >= ha + hf && x < ha + hf + hsw) ? hp : ~hp;
    e.vs = (y >= va + vf && y < va + vf + vsw) ? vp : ~vp;
    e.ls = (x == 0);
    e.fs = (p == 0);
    return e;
  endfunction

  function automatic obs_t exp_a();
    return model(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  function automatic obs_t exp_b();
    return model(n_b, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
  endfunction

  function automatic obs_t got_a();
    return {hs_a, vs_a, de_a, ls_a, fs_a, 6'd0, sx_a, 6'd0, sy_a};
  endfunction

  function automatic obs_t got_b();
    return {hs_b, vs_b, de_b, ls_b, fs_b, 12'd0, sx_b, 12'd0, sy_b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Length of each contiguous active run, discarding runs cut short by reset.
  task automatic run_track(input string tag, input logic r, input logic act,
                           input int want, inout int cnt);
    if (r) cnt = 0;
    else if (act) cnt++;
    else begin
      if (cnt != 0) check(tag, 64'(cnt), 64'(want));
      cnt = 0;
    end
  endtask

  task automatic interval_track(input string tag, input logic r, input logic strobe,
                                input int period, inout int last);
    if (r) last = -1;
    else if (strobe) begin
      if (last >= 0) check(tag, 64'(cyc - last), 64'(period));
      last = cyc;
    end
  endtask

  task automatic sample();
    check("pos_a", got_a(), exp_a());
    check("pos_b", got_b(), exp_b());
    run_track("hsync_run_a", rst_a, !hs_a, 96, hs_run_a);
    run_track("de_run_a", rst_a, de_a, 640, de_run_a);
    interval_track("line_period_a", rst_a, ls_a, 800, ls_last_a);
    run_track("hsync_run_b", rst_b, hs_b, 2, hs_run_b);
    run_track("vsync_run_b", rst_b, vs_b, 8, vs_run_b);
    run_track("de_run_b", rst_b, de_b, 4, de_run_b);
    interval_track("frame_period_b", rst_b, fs_b, 48, fs_last_b);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_a) n_a++;
    if (!rst_b) n_b++;
    @(negedge clk);
    sample();
  endtask

  // Random reset pulses on the small instance; assertion is checked before any edge.
  task automatic rand_b();
    if (!rst_b && $urandom_range(0, 299) == 0) begin
      rst_b = 1'b1;
      n_b   = 0;
      #1;
      check("async_rst_b", got_b(), exp_b());
    end else if (rst_b && $urandom_range(0, 2) == 0) begin
      rst_b = 1'b0;
    end
  endtask

  initial begin
    repeat (3) step();
    rst_a = 1'b0;
    rst_b = 1'b0;

    step();
    check("startup_fs_a", 64'(fs_a), 64'd1);
    check("startup_de_a", 64'(de_a), 64'd1);
    step();
    check("startup_sx1_a", 64'(sx_a), 64'd1);

    // Run to sx=300, sy=2 so the default instance crosses two line wraps.
    while (n_a < 1901) begin
      step();
      rand_b();
    end
    check("pre_rst_sx_a", 64'(sx_a), 64'd300);
    check("pre_rst_sy_a", 64'(sy_a), 64'd2);

    rst_a = 1'b1;
    n_a   = 0;
    #1;
    check("async_rst_a", got_a(), exp_a());
    check("async_rst_hs_a", 64'(hs_a), 64'd1);
    check("async_rst_vs_a", 64'(vs_a), 64'd1);
    repeat ($urandom_range(1, 4)) begin
      step();
      rand_b();
    end
    rst_a = 1'b0;
    step();
    check("restart_fs_a", 64'(fs_a), 64'd1);
    check("restart_sx_a", 64'(sx_a), 64'd0);

    repeat (1000) begin
      step();
      rand_b();
    end
    check("after_wrap_sy_a", 64'(sy_a), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
